regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised successor of the 32x64 register file: N-read/1-write register bank plus
//  per-register pending scoreboard. Sits in the decode stage of the pipelined ARM core.
//  Write-through bypass and a constant zero register serve the datapath. Pending bits serve
//  hazard detection: set at issue, cleared at writeback.
// PARAMETERS
//  WIDTH     64  data width of each register
//  NREGS     32  number of architectural registers (power of 2, >=4)
//  NRD       2   number of asynchronous read ports
//  ZERO_REG  31  index that always reads 0, is never written, is never pending
//  RST_IDX   1   1: reset value of reg i is i; 0: all registers reset to 0
//  (local) AW = $clog2(NREGS), CW = $clog2(NREGS+1)
// PORTS
//  clk       in   1           clock, all state updates on posedge
//  reset     in   1           asynchronous, active-high
//  ra        in   NRD x AW    read addresses
//  rd        out  NRD x WIDTH read data (combinational)
//  rd_ready  out  NRD         1 = rd[i] holds a committed or bypassed value (not pending)
//  we3       in   1           writeback enable
//  wa3       in   AW          writeback address
//  wd3       in   WIDTH       writeback data
//  iss_valid in   1           instruction issued that will write iss_wa
//  iss_wa    in   AW          destination of issuing instruction
//  flush     in   1           clear all pending bits (pipeline squash)
//  pend_cnt  out  CW          number of registers currently pending (registered)
//  iss_dup   out  1           sticky: issue targeted an already-pending register
// BEHAVIOUR
//  Reset (async, takes effect immediately): reg[i] = RST_IDX ? i : 0, reg[ZERO_REG] = 0;
//   pending = 0; pend_cnt = 0; iss_dup = 0. Asserting reset mid-operation discards in-flight writes.
//  Write: posedge clk, if we3 && wa3 != ZERO_REG then reg[wa3] <= wd3; latency 1 cycle.
//  Read port i (combinational, zero latency), in priority order:
//   ra[i]==ZERO_REG -> 0; we3 && wa3==ra[i] -> wd3 (bypass); else reg[ra[i]].
//   A write to ZERO_REG is never bypassed.
//  rd_ready[i] = (ra[i]==ZERO_REG) | ~pending[ra[i]] | (we3 && wa3==ra[i]).
//  Pending update per posedge (per register r != ZERO_REG):
//   flush            -> pending[r] <= 0 (overrides everything, incl. same-cycle issue)
//   set  = iss_valid && iss_wa==r; clr = we3 && wa3==r
//   set & clr        -> stays 1 (newer producer wins)
//   set only -> 1;  clr only -> 0;  neither -> hold
//   we3 to a non-pending register is legal: the data is written and pending stays 0.
//  pend_cnt: registered popcount of the next pending vector; it therefore always equals
//   popcount(pending) and needs no incremental arithmetic. Range 0..NREGS-1, never wraps.
//  iss_dup: set at posedge when iss_valid && !flush && iss_wa != ZERO_REG
//   && pending[iss_wa] && !(we3 && wa3==iss_wa); cleared only by reset.
//  Issue to ZERO_REG: ignored (no pending, no iss_dup).
//  Multiple read ports may share an address; each gets identical rd/rd_ready.
// STRUCTURE
//  Package regfile_pkg: default WIDTH/NREGS/ZERO_REG constants, typedef reg_addr_t
//   (logic [AW-1:0]) and reg_data_t (logic [WIDTH-1:0]).
//  Sub-module regfile_scoreboard: pending vector, flush/set/clr priority, pend_cnt, iss_dup.
//  Top: storage array, write port, NRD read/bypass muxes in a generate loop.
// TESTING
//  1 reset; read ra={5,31} -> rd={5,0}, rd_ready=2'b11, pend_cnt=0.
//  2 we3=1 wa3=3 wd3=0xDEAD, ra0=3 same cycle -> rd0=0xDEAD (bypass); next cycle still 0xDEAD.
//  3 we3=1 wa3=31 wd3=0xFFFF; ra0=31 -> rd0=0 same cycle and after.
//  4 issue wa=7 -> pending, rd_ready0=0 for ra0=7, pend_cnt=1; writeback 7 -> rd_ready=1
//    same cycle via bypass, pend_cnt=0 next cycle.
//  5 same cycle iss_wa=4 and we3 wa3=4 while 4 pending -> stays pending, pend_cnt unchanged,
//    iss_dup stays 0; issue 4 again with no writeback -> iss_dup=1.
//  6 issue 1,2,3 over 3 cycles (pend_cnt=3), then flush+issue 9 same cycle -> pend_cnt=0,
//    9 not pending; assert reset mid-run -> reg[5] reads 5 again, iss_dup=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register bank with its pending-bit scoreboard.
package regfile_pkg;
   localparam int WIDTH_D    = 64;
   localparam int NREGS_D    = 32;
   localparam int ZERO_REG_D = 31;
   localparam int AW_D       = $clog2(NREGS_D);

   typedef logic [AW_D-1:0]    reg_addr_t;
   typedef logic [WIDTH_D-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer tracking: one bit per register, set at issue, cleared at writeback.
import regfile_pkg::*;

module regfile_scoreboard #(
   parameter int NREGS    = NREGS_D,
   parameter int ZERO_REG = ZERO_REG_D,
   localparam int AW      = $clog2(NREGS),
   localparam int CW      = $clog2(NREGS+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             iss_valid,
   input  logic [AW-1:0]    iss_wa,
   input  logic             we3,
   input  logic [AW-1:0]    wa3,
   input  logic             flush,
   output logic [NREGS-1:0] pending,
   output logic [CW-1:0]    pend_cnt,
   output logic             iss_dup
);
   localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

   logic [NREGS-1:0] pend_nxt;
   logic [CW-1:0]    cnt_nxt;
   logic             dup_hit;

   always_comb begin
      pend_nxt = '0;
      cnt_nxt  = '0;
      for (int r = 0; r < NREGS; r++) begin
         if (r == ZERO_REG || flush)
            pend_nxt[r] = 1'b0;
         else if (iss_valid && iss_wa == AW'(r))
            pend_nxt[r] = 1'b1;            // newer producer beats same-cycle writeback
         else if (we3 && wa3 == AW'(r))
            pend_nxt[r] = 1'b0;
         else
            pend_nxt[r] = pending[r];
         cnt_nxt = cnt_nxt + CW'(pend_nxt[r]);
      end
   end

   assign dup_hit = iss_valid && !flush && iss_wa != ZA && pending[iss_wa]
                    && !(we3 && wa3 == iss_wa);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending  <= '0;
         pend_cnt <= '0;
         iss_dup  <= 1'b0;
      end else begin
         pending  <= pend_nxt;
         pend_cnt <= cnt_nxt;
         if (dup_hit) iss_dup <= 1'b1;
      end
   end
endmodule

// File: rtl/regfile_sb.sv
// N-read/1-write register bank with write-through bypass, hard zero register and scoreboard.
import regfile_pkg::*;

module regfile_sb #(
   parameter int WIDTH    = WIDTH_D,
   parameter int NREGS    = NREGS_D,
   parameter int NRD      = 2,
   parameter int ZERO_REG = ZERO_REG_D,
   parameter int RST_IDX  = 1,
   localparam int AW      = $clog2(NREGS),
   localparam int CW      = $clog2(NREGS+1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NRD-1:0][AW-1:0]    ra,
   output logic [NRD-1:0][WIDTH-1:0] rd,
   output logic [NRD-1:0]            rd_ready,
   input  logic                      we3,
   input  logic [AW-1:0]             wa3,
   input  logic [WIDTH-1:0]          wd3,
   input  logic                      iss_valid,
   input  logic [AW-1:0]             iss_wa,
   input  logic                      flush,
   output logic [CW-1:0]             pend_cnt,
   output logic                      iss_dup
);
   localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

   logic [WIDTH-1:0] regs [NREGS];
   logic [NREGS-1:0] pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= (RST_IDX != 0 && i != ZERO_REG) ? WIDTH'(i) : '0;
      end else if (we3 && wa3 != ZA) begin
         regs[wa3] <= wd3;
      end
   end

   // Zero-register check comes first so a write to it is never bypassed.
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic byp;
      assign byp         = we3 && wa3 == ra[i];
      assign rd[i]       = (ra[i] == ZA) ? '0 : byp ? wd3 : regs[ra[i]];
      assign rd_ready[i] = (ra[i] == ZA) | ~pending[ra[i]] | byp;
   end

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .iss_valid (iss_valid),
      .iss_wa    (iss_wa),
      .we3       (we3),
      .wa3       (wa3),
      .flush     (flush),
      .pending   (pending),
      .pend_cnt  (pend_cnt),
      .iss_dup   (iss_dup)
   );
endmodule
